// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer slice: sequencer state
// encoding, default parameter values and the branch-target table contents.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned D_DEFAULT        = 12;
  localparam int unsigned START_PC_DEFAULT = 0;

  // Branch-target table: index -> absolute fetch address.
  localparam logic [3:0]  LUT_IDX1 = 4'd1;
  localparam logic [3:0]  LUT_IDX2 = 4'd2;
  localparam logic [3:0]  LUT_IDX3 = 4'd3;
  localparam logic [3:0]  LUT_IDX4 = 4'd4;
  localparam int unsigned LUT_TGT1 = 45;
  localparam int unsigned LUT_TGT2 = 69;
  localparam int unsigned LUT_TGT3 = 80;
  localparam int unsigned LUT_TGT4 = 91;

endpackage

// File: rtl/fetch_sequencer_branch_target_table.sv
// branch_target_table: combinational lookup of a branch target address.
// Ports:
//   index  [3:0]   table index supplied with the branch
//   target [D-1:0] target address (0 when the index is unmapped)
//   Hit            high when index maps to a table entry
module branch_target_table
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned D = D_DEFAULT
) (
  input  logic [3:0]   index,
  output logic [D-1:0] target,
  output logic         Hit
);

  always_comb begin
    target = '0;
    Hit    = 1'b0;
    unique case (index)
      LUT_IDX1: begin target = D'(LUT_TGT1); Hit = 1'b1; end
      LUT_IDX2: begin target = D'(LUT_TGT2); Hit = 1'b1; end
      LUT_IDX3: begin target = D'(LUT_TGT3); Hit = 1'b1; end
      LUT_IDX4: begin target = D'(LUT_TGT4); Hit = 1'b1; end
      default:  begin target = '0;           Hit = 1'b0; end
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/RUN/HALT program-counter sequencer with
// table-driven branch redirects, stall hold and a retired-cycle counter.
// Ports:
//   Clk, Reset       clock, synchronous active-high reset
//   Start            start/restart (honoured in IDLE and HALT only)
//   Stall            freeze PC, state and counters for the cycle
//   BranchEn,LutAddr taken branch and its table index
//   HaltInstr        terminate the program
//   PC               registered program counter
//   Fetching         high in RUN
//   Flush            one-cycle pulse after a branch redirect
//   Done             high in HALT
//   BadTarget        sticky: branch taken with an unmapped index
//   InstrCount       saturating count of non-stalled RUN cycles
// All outputs are decoded from registers only.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned D        = D_DEFAULT,
  parameter int unsigned START_PC = START_PC_DEFAULT
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchEn,
  input  logic [3:0]   LutAddr,
  input  logic         HaltInstr,
  output logic [D-1:0] PC,
  output logic         Fetching,
  output logic         Flush,
  output logic         Done,
  output logic         BadTarget,
  output logic [15:0]  InstrCount
);

  state_t       state, state_n;
  logic [D-1:0] pc_q, pc_n;
  logic [15:0]  cnt_q, cnt_n;
  logic         bad_q, bad_n;
  logic         flush_q, flush_n;

  logic [D-1:0] lut_target;
  logic         lut_hit;

  branch_target_table #(.D(D)) u_table (
    .index  (LutAddr),
    .target (lut_target),
    .Hit    (lut_hit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pc_q    <= D'(START_PC);
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      cnt_q   <= cnt_n;
      bad_q   <= bad_n;
      flush_q <= flush_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    cnt_n   = cnt_q;
    bad_n   = bad_q;
    flush_n = 1'b0;
    unique case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_n = RUN;
          pc_n    = D'(START_PC);
          cnt_n   = '0;
          bad_n   = 1'b0;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (cnt_q != '1) cnt_n = cnt_q + 16'd1;
          if (HaltInstr) begin
            state_n = HALT;
          end else if (BranchEn && lut_hit) begin
            pc_n    = lut_target;
            flush_n = 1'b1;
          end else begin
            // Unmapped branch targets fall through sequentially and
            // latch the sticky error instead of redirecting.
            pc_n = pc_q + D'(1);
            if (BranchEn) bad_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign PC         = pc_q;
  assign Fetching   = (state == RUN);
  assign Done       = (state == HALT);
  assign Flush      = flush_q;
  assign BadTarget  = bad_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1, Start = 1'b0, Stall = 1'b0;
  logic        BranchEn = 1'b0, HaltInstr = 1'b0;
  logic [3:0]  LutAddr = 4'd0;

  logic [11:0] pc0, pc1;
  logic        fe0, fe1, fl0, fl1, dn0, dn1, bt0, bt1;
  logic [15:0] ic0, ic1;

  int unsigned assertions = 0;
  int unsigned failures   = 0;

  // reference model state, one slot per instance
  int m_st  [2];   // 0 idle, 1 run, 2 halt
  int m_pc  [2];
  int m_cnt [2];
  int m_bad [2];
  int m_fl  [2];
  int m_sp  [2] = '{0, 4094};

  always #5 Clk = ~Clk;

  fetch_sequencer #(.D(12), .START_PC(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .BranchEn(BranchEn), .LutAddr(LutAddr), .HaltInstr(HaltInstr),
    .PC(pc0), .Fetching(fe0), .Flush(fl0), .Done(dn0),
    .BadTarget(bt0), .InstrCount(ic0)
  );

  fetch_sequencer #(.D(12), .START_PC(4094)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .BranchEn(BranchEn), .LutAddr(LutAddr), .HaltInstr(HaltInstr),
    .PC(pc1), .Fetching(fe1), .Flush(fl1), .Done(dn1),
    .BadTarget(bt1), .InstrCount(ic1)
  );

  function automatic int table_target(input int idx);
    case (idx)
      1: return 45;
      2: return 69;
      3: return 80;
      4: return 91;
      default: return -1;
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_st[i] = 0; m_pc[i] = m_sp[i]; m_cnt[i] = 0; m_bad[i] = 0; m_fl[i] = 0;
      end else if (m_st[i] == 1) begin
        m_fl[i] = 0;
        if (!Stall) begin
          if (m_cnt[i] < 65535) m_cnt[i] = m_cnt[i] + 1;
          if (HaltInstr) m_st[i] = 2;
          else if (BranchEn && table_target(int'(LutAddr)) >= 0) begin
            m_pc[i] = table_target(int'(LutAddr));
            m_fl[i] = 1;
          end else begin
            m_pc[i] = (m_pc[i] + 1) % 4096;
            if (BranchEn) m_bad[i] = 1;
          end
        end
      end else begin
        m_fl[i] = 0;
        if (Start) begin
          m_st[i] = 1; m_pc[i] = m_sp[i]; m_cnt[i] = 0; m_bad[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("pc0",    32'(pc0), 32'(m_pc[0]));
    chk("fetch0", 32'(fe0), 32'(m_st[0] == 1));
    chk("done0",  32'(dn0), 32'(m_st[0] == 2));
    chk("flush0", 32'(fl0), 32'(m_fl[0]));
    chk("bad0",   32'(bt0), 32'(m_bad[0]));
    chk("cnt0",   32'(ic0), 32'(m_cnt[0]));
    chk("pc1",    32'(pc1), 32'(m_pc[1]));
    chk("fetch1", 32'(fe1), 32'(m_st[1] == 1));
    chk("done1",  32'(dn1), 32'(m_st[1] == 2));
    chk("flush1", 32'(fl1), 32'(m_fl[1]));
    chk("bad1",   32'(bt1), 32'(m_bad[1]));
    chk("cnt1",   32'(ic1), 32'(m_cnt[1]));
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    Reset = 1'b0; Start = 1'b0; Stall = 1'b0;
    BranchEn = 1'b0; HaltInstr = 1'b0; LutAddr = 4'd0;
  endtask

  task automatic restart();
    idle_inputs(); Reset = 1'b1; step();
    Reset = 1'b0; Start = 1'b1; step();
    Start = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    chk("rst_pc", 32'(pc0), 32'd0);
    chk("rst_pc1", 32'(pc1), 32'd4094);
    chk("rst_fetch", 32'(fe0), 32'd0);

    // start then sequential fetch
    Reset = 1'b0; Start = 1'b1; step();
    Start = 1'b0;
    chk("start_pc", 32'(pc0), 32'd0);
    chk("start_pc1", 32'(pc1), 32'd4094);
    step(); chk("wrap_4095", 32'(pc1), 32'd4095);
    step(); chk("wrap_0", 32'(pc1), 32'd0);
    step(); chk("wrap_1", 32'(pc1), 32'd1);
    repeat (2) step();
    chk("seq_pc5", 32'(pc0), 32'd5);
    chk("seq_cnt5", 32'(ic0), 32'd5);
    chk("seq_fetch", 32'(fe0), 32'd1);

    // Start in RUN is ignored
    Start = 1'b1; repeat (5) step(); Start = 1'b0;
    chk("start_ign_pc", 32'(pc0), 32'd10);

    // mapped branches
    BranchEn = 1'b1; LutAddr = 4'd2; step();
    chk("br_pc69", 32'(pc0), 32'd69);
    chk("br_flush", 32'(fl0), 32'd1);
    LutAddr = 4'd4; step();
    chk("br_pc91", 32'(pc0), 32'd91);
    BranchEn = 1'b0; step();
    chk("br_flush_end", 32'(fl0), 32'd0);
    chk("br_pc92", 32'(pc0), 32'd92);

    // unmapped branch at PC=7
    restart();
    repeat (7) step();
    chk("ub_pc7", 32'(pc0), 32'd7);
    BranchEn = 1'b1; LutAddr = 4'd9; step(); BranchEn = 1'b0;
    chk("ub_pc8", 32'(pc0), 32'd8);
    chk("ub_bad", 32'(bt0), 32'd1);
    chk("ub_noflush", 32'(fl0), 32'd0);
    repeat (3) step();
    chk("ub_bad_held", 32'(bt0), 32'd1);

    // stall with pending branch at PC=3
    restart();
    repeat (3) step();
    Stall = 1'b1; BranchEn = 1'b1; LutAddr = 4'd1;
    repeat (3) step();
    chk("stall_pc", 32'(pc0), 32'd3);
    chk("stall_cnt", 32'(ic0), 32'd3);
    Stall = 1'b0; step(); BranchEn = 1'b0;
    chk("stall_br_pc", 32'(pc0), 32'd45);
    chk("stall_br_cnt", 32'(ic0), 32'd4);

    // halt beats branch at PC=20
    restart();
    repeat (20) step();
    HaltInstr = 1'b1; BranchEn = 1'b1; LutAddr = 4'd3; step();
    HaltInstr = 1'b0; BranchEn = 1'b0;
    chk("halt_done", 32'(dn0), 32'd1);
    chk("halt_pc", 32'(pc0), 32'd20);
    chk("halt_cnt", 32'(ic0), 32'd21);
    repeat (3) step();
    chk("halt_hold", 32'(pc0), 32'd20);
    Start = 1'b1; step(); Start = 1'b0;
    chk("restart_pc", 32'(pc0), 32'd0);
    chk("restart_done", 32'(dn0), 32'd0);
    chk("restart_cnt", 32'(ic0), 32'd0);

    // reset mid-run beats every other input
    repeat (4) step();
    Reset = 1'b1; Start = 1'b1; BranchEn = 1'b1; LutAddr = 4'd2; step();
    idle_inputs();
    chk("rr_fetch", 32'(fe0), 32'd0);
    chk("rr_pc", 32'(pc0), 32'd0);
    chk("rr_pc1", 32'(pc1), 32'd4094);
    chk("rr_cnt", 32'(ic0), 32'd0);
    chk("rr_flush", 32'(fl0), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      Reset     = ($urandom_range(0, 39) == 0);
      Start     = ($urandom_range(0, 5) == 0);
      Stall     = ($urandom_range(0, 3) == 0);
      BranchEn  = ($urandom_range(0, 2) == 0);
      LutAddr   = 4'($urandom_range(0, 15));
      HaltInstr = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
